// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared opcodes, stage control type and lookahead helper for the pipelined CLA adder
// Purpose : common definitions imported by cla_segment and pipelined_cla_adder.
// Contents: OP_ADD/OP_SUB opcodes, stage_ctl_t per-stage control word,
//           cla_gp() single-bit generate/propagate.
package cla_pkg;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   // Control part of the per-stage payload. The WIDTH-dependent operand and
   // partial-sum words travel in parallel arrays alongside it, because a
   // package-level struct cannot be sized by the adder's WIDTH parameter.
   typedef struct packed {
      logic valid;
      logic sub;
      logic carry;
   } stage_ctl_t;

   // Returns {generate, propagate} for one bit position.
   function automatic logic [1:0] cla_gp(input logic a, input logic b);
      return {a & b, a ^ b};
   endfunction

endpackage

// File: rtl/cla_segment.sv
// rtl/cla_segment.sv - combinational SEG-bit carry-lookahead adder segment
// Purpose : adds one SEG-bit slice using generate/propagate lookahead.
// Ports   : a_i   [SEG-1:0] operand A slice
//           b_i   [SEG-1:0] operand B' slice (already inverted for subtract)
//           c_i             carry into the slice
//           sum_o [SEG-1:0] slice sum
//           c_o             carry out of the slice
module cla_segment
   import cla_pkg::*;
#(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a_i,
   input  logic [SEG-1:0] b_i,
   input  logic           c_i,
   output logic [SEG-1:0] sum_o,
   output logic           c_o
);

   logic [SEG-1:0] g;
   logic [SEG-1:0] p;
   logic [SEG:0]   c;
   logic           grp_g;
   logic           grp_p;

   always_comb begin
      g = '0;
      p = '0;
      for (int i = 0; i < SEG; i++) begin
         {g[i], p[i]} = cla_gp(a_i[i], b_i[i]);
      end
   end

   // Each carry is formed from the group generate/propagate of bits [i:0]
   // and the slice carry-in, rather than from the previous bit's carry.
   always_comb begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      c     = '0;
      c[0]  = c_i;
      for (int i = 0; i < SEG; i++) begin
         grp_g    = g[i] | (p[i] & grp_g);
         grp_p    = grp_p & p[i];
         c[i + 1] = grp_g | (grp_p & c_i);
      end
   end

   assign sum_o = p ^ c[SEG-1:0];
   assign c_o   = c[SEG];

endmodule

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - STAGES-deep pipelined carry-lookahead add/subtract with valid/ready
// Purpose : WIDTH-bit A+B+c0 / A-B split into STAGES lookahead segments with a
//           registered carry between them; overflow, carry, less-than, not-equal flags.
// Ports   : clock, reset (async, active-low)
//           in_valid/in_ready, in_a, in_b, in_sub, in_c0   operand beat
//           out_valid/out_ready, out_result, out_cout, out_ovf, out_lt, out_ne   result beat
// Options : CLA_SATURATE_EN - clamp out_result to the signed extreme on overflow.
module pipelined_cla_adder
   import cla_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_sub,
   input  logic             in_c0,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_lt,
   output logic             out_ne
);

   localparam int SEG = WIDTH / STAGES;
   localparam int L   = STAGES - 1;
   localparam int MSB = WIDTH - 1;

   // Stage registers: register k holds a beat whose slices [0..k] are summed.
   stage_ctl_t       ctl_q [STAGES];
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] bp_q  [STAGES];
   logic [WIDTH-1:0] sum_q [STAGES];

   stage_ctl_t       ctl_d [STAGES];
   logic [WIDTH-1:0] a_d   [STAGES];
   logic [WIDTH-1:0] bp_d  [STAGES];
   logic [WIDTH-1:0] sum_d [STAGES];

   // What each stage's segment works on: the prepared inputs for stage 0,
   // otherwise the previous stage register.
   stage_ctl_t       src_ctl [STAGES];
   logic [WIDTH-1:0] src_a   [STAGES];
   logic [WIDTH-1:0] src_bp  [STAGES];
   logic [WIDTH-1:0] src_sum [STAGES];

   logic [SEG-1:0]   seg_sum [STAGES];
   logic             seg_c   [STAGES];
   logic [STAGES-1:0] adv;

   // A stage advances if it is empty or everything below it advances; unrolled,
   // that is out_ready or any empty stage at or after k. Written this way so the
   // ready chain is a flat OR with no self-referencing vector.
   always_comb begin
      logic room;
      adv = '0;
      for (int k = 0; k < STAGES; k++) begin
         room = out_ready;
         for (int j = k; j < STAGES; j++) begin
            room = room | ~ctl_q[j].valid;
         end
         adv[k] = room;
      end
   end

   assign in_ready = adv[0];

   always_comb begin
      src_ctl[0].valid = in_valid;
      src_ctl[0].sub   = in_sub;
      src_ctl[0].carry = (in_sub == OP_SUB) ? 1'b1 : in_c0;
      src_a[0]         = in_a;
      src_bp[0]        = (in_sub == OP_ADD) ? in_b : ~in_b;
      src_sum[0]       = '0;
      for (int k = 1; k < STAGES; k++) begin
         src_ctl[k] = ctl_q[k-1];
         src_a[k]   = a_q[k-1];
         src_bp[k]  = bp_q[k-1];
         src_sum[k] = sum_q[k-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      cla_segment #(.SEG(SEG)) u_seg (
         .a_i   (src_a[k][k*SEG +: SEG]),
         .b_i   (src_bp[k][k*SEG +: SEG]),
         .c_i   (src_ctl[k].carry),
         .sum_o (seg_sum[k]),
         .c_o   (seg_c[k])
      );
   end

   always_comb begin
      for (int k = 0; k < STAGES; k++) begin
         ctl_d[k].valid = src_ctl[k].valid;
         ctl_d[k].sub   = src_ctl[k].sub;
         ctl_d[k].carry = seg_c[k];
         a_d[k]         = src_a[k];
         bp_d[k]        = src_bp[k];
         sum_d[k]       = src_sum[k];
         sum_d[k][k*SEG +: SEG] = seg_sum[k];
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < STAGES; k++) begin
            ctl_q[k] <= '0;
            a_q[k]   <= '0;
            bp_q[k]  <= '0;
            sum_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
               ctl_q[k] <= ctl_d[k];
               a_q[k]   <= a_d[k];
               bp_q[k]  <= bp_d[k];
               sum_q[k] <= sum_d[k];
            end
         end
      end
   end

   // Flags are derived from the last stage register only, so they hold still
   // for as long as the result is stalled.
   logic [WIDTH-1:0] fin_sum;
   logic             fin_ovf;

   assign fin_sum   = sum_q[L];
   assign fin_ovf   = (a_q[L][MSB] == bp_q[L][MSB]) && (fin_sum[MSB] != a_q[L][MSB]);
   assign out_valid = ctl_q[L].valid;
   assign out_cout  = ctl_q[L].carry;
   assign out_ovf   = fin_ovf;
   assign out_lt    = ctl_q[L].sub & (fin_sum[MSB] ^ fin_ovf);
   assign out_ne    = ctl_q[L].sub & (|fin_sum);

`ifdef CLA_SATURATE_EN
   always_comb begin
      out_result = fin_sum;
      if (fin_ovf) begin
         out_result = a_q[L][MSB] ? {1'b1, {MSB{1'b0}}} : {1'b0, {MSB{1'b1}}};
      end
   end
`else
   assign out_result = fin_sum;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder
module tb_pipelined_cla_adder;

   localparam int WIDTH  = 32;
   localparam int STAGES = 4;

   logic             clock = 1'b0;
   logic             reset = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [WIDTH-1:0] in_a = '0;
   logic [WIDTH-1:0] in_b = '0;
   logic             in_sub = 1'b0;
   logic             in_c0 = 1'b0;
   logic             out_valid;
   logic             out_ready = 1'b0;
   logic [WIDTH-1:0] out_result;
   logic             out_cout;
   logic             out_ovf;
   logic             out_lt;
   logic             out_ne;

   pipelined_cla_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clock      (clock),
      .reset      (reset),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .in_sub     (in_sub),
      .in_c0      (in_c0),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_cout   (out_cout),
      .out_ovf    (out_ovf),
      .out_lt     (out_lt),
      .out_ne     (out_ne)
   );

   always #5 clock = ~clock;

   typedef logic [35:0] exp_t;   // {result, cout, ovf, lt, ne}

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];
   logic [31:0] edge_vals [5];

   // Reference: signed/unsigned integer arithmetic on 64-bit values.
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic sub, input logic c0);
      longint      sa, sb, s;
      logic [63:0] u, sv;
      logic [31:0] r;
      logic        cout, ovf, lt, ne;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (sub) begin
         s    = sa - sb;
         cout = (a >= b);
         lt   = (sa < sb);
         ne   = (a != b);
      end else begin
         s    = sa + sb + longint'(c0);
         u    = 64'(a) + 64'(b) + 64'(c0);
         cout = u[32];
         lt   = 1'b0;
         ne   = 1'b0;
      end
      ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      sv  = s;
      r   = sv[31:0];
`ifdef CLA_SATURATE_EN
      if (ovf) r = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
      return {r, cout, ovf, lt, ne};
   endfunction

   function automatic exp_t observed();
      return {out_result, out_cout, out_ovf, out_lt, out_ne};
   endfunction

   function automatic logic [31:0] pick_operand();
      int idx;
      if ($urandom_range(0, 3) == 0) begin
         idx = $urandom_range(0, 4);
         return edge_vals[idx];
      end
      return $urandom();
   endfunction

   task automatic test_reset();
      reset = 1'b0;
      #3;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (observed() !== 36'h0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", observed()); end
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic test_directed();
      logic [31:0] va [9];
      logic [31:0] vb [9];
      logic        vs [9];
      logic        vc [9];
      exp_t        e;
      va = '{32'h1, 32'hFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h5, 32'h7, 32'h8000_0000, 32'h1234_5678, 32'h3};
      vb = '{32'h1, 32'h1,  32'h1,         32'h1,         32'h7, 32'h7, 32'h1,         32'h0FED_CBA9, 32'h9};
      vs = '{1'b0,  1'b0,   1'b0,          1'b0,          1'b1,  1'b1,  1'b1,          1'b0,          1'b1};
      vc = '{1'b0,  1'b0,   1'b0,          1'b0,          1'b0,  1'b0,  1'b0,          1'b1,          1'b1};
      for (int t = 0; t < 9; t++) begin
         e = model(va[t], vb[t], vs[t], vc[t]);
         @(negedge clock);
         in_valid = 1'b1; in_a = va[t]; in_b = vb[t]; in_sub = vs[t]; in_c0 = vc[t];
         out_ready = 1'b1;
         #1;
         checks++;
         if (in_ready !== 1'b1) begin errors++; $display("FAIL directed_in_ready[%0d]: got %b expected 1", t, in_ready); end
         @(posedge clock);
         @(negedge clock);
         in_valid = 1'b0;
         for (int n = 1; n <= STAGES; n++) begin
            #1;
            checks++;
            if (n < STAGES) begin
               if (out_valid !== 1'b0) begin errors++; $display("FAIL directed_early_valid[%0d] edge %0d: got %b expected 0", t, n, out_valid); end
               @(negedge clock);
            end else begin
               if (out_valid !== 1'b1 || observed() !== e) begin
                  errors++;
                  $display("FAIL directed_result[%0d]: got valid=%b %h expected valid=1 %h", t, out_valid, observed(), e);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int   sent = 0, emitted = 0, c = 0;
      logic exp_rdy;
      exp_q.delete();
      while (emitted < 6 && c < 40) begin
         c++;
         @(negedge clock);
         in_valid  = (sent < 6);
         in_a      = pick_operand();
         in_b      = pick_operand();
         in_sub    = $urandom_range(0, 1);
         in_c0     = $urandom_range(0, 1);
         out_ready = !(c >= 2 && c <= 6);
         #1;
         exp_rdy = !(exp_q.size() == STAGES && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin errors++; $display("FAIL b2b_in_ready cycle %0d: got %b expected %b", c, in_ready, exp_rdy); end
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL b2b_spurious cycle %0d: got valid=1 expected valid=0", c);
            end else if (observed() !== exp_q[0]) begin
               errors++; $display("FAIL b2b_result cycle %0d: got %h expected %h", c, observed(), exp_q[0]);
            end
            if (out_ready && exp_q.size() != 0) begin void'(exp_q.pop_front()); emitted++; end
         end
         if (in_valid && in_ready) begin exp_q.push_back(model(in_a, in_b, in_sub, in_c0)); sent++; end
      end
      checks++;
      if (emitted != 6) begin errors++; $display("FAIL b2b_count: got %0d beats expected 6", emitted); end
   endtask

   task automatic test_random();
      int   c = 0;
      logic exp_rdy;
      exp_q.delete();
      while (c < 600 && (c < 300 || exp_q.size() != 0)) begin
         c++;
         @(negedge clock);
         in_valid  = (c < 300) && ($urandom_range(0, 9) < 7);
         in_a      = pick_operand();
         in_b      = pick_operand();
         in_sub    = $urandom_range(0, 1);
         in_c0     = $urandom_range(0, 1);
         out_ready = (c >= 300) || ($urandom_range(0, 9) < 6);
         #1;
         exp_rdy = !(exp_q.size() == STAGES && !out_ready);
         checks++;
         if (in_ready !== exp_rdy) begin errors++; $display("FAIL rand_in_ready cycle %0d: got %b expected %b", c, in_ready, exp_rdy); end
         if (out_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("FAIL rand_spurious cycle %0d: got valid=1 expected valid=0", c);
            end else if (observed() !== exp_q[0]) begin
               errors++; $display("FAIL rand_result cycle %0d: got %h expected %h", c, observed(), exp_q[0]);
            end
            if (out_ready && exp_q.size() != 0) void'(exp_q.pop_front());
         end
         if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_sub, in_c0));
      end
      checks++;
      if (exp_q.size() != 0) begin errors++; $display("FAIL rand_drain: got %0d beats left expected 0", exp_q.size()); end
   endtask

   task automatic test_reset_midstream();
      exp_t e;
      for (int t = 0; t < 3; t++) begin
         @(negedge clock);
         in_valid = 1'b1; in_a = 32'h100 + t; in_b = 32'h20; in_sub = 1'b0; in_c0 = 1'b0;
         out_ready = 1'b0;
      end
      @(negedge clock);
      in_valid = 1'b0;
      @(negedge clock);
      #1;
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL midreset_pre_valid: got %b expected 1", out_valid); end
      #1;
      reset = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_out_valid: got %b expected 0", out_valid); end
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL midreset_in_ready: got %b expected 1", in_ready); end
      checks++;
      if (observed() !== 36'h0) begin errors++; $display("FAIL midreset_outputs: got %h expected 0", observed()); end
      @(negedge clock);
      reset = 1'b1;
      e = model(32'h2, 32'h3, 1'b0, 1'b0);
      @(negedge clock);
      in_valid = 1'b1; in_a = 32'h2; in_b = 32'h3; in_sub = 1'b0; in_c0 = 1'b0; out_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      for (int n = 1; n <= STAGES + 3; n++) begin
         #1;
         checks++;
         if (n == STAGES) begin
            if (out_valid !== 1'b1 || observed() !== e) begin
               errors++; $display("FAIL midreset_new_add: got valid=%b %h expected valid=1 %h", out_valid, observed(), e);
            end
         end else if (out_valid !== 1'b0) begin
            errors++; $display("FAIL midreset_stale edge %0d: got valid=1 expected valid=0", n);
         end
         @(negedge clock);
      end
   endtask

   initial begin
      edge_vals = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
      test_reset();
      test_directed();
      test_back_to_back();
      test_random();
      test_reset_midstream();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pipelined_cla_adder.md
Name: pipelined_cla_adder

Overview:
- Parametrised, pipelined successor to the 32-bit combinational carry-lookahead adder.
- Splits a WIDTH-bit add/subtract into STAGES carry-lookahead segments, with a registered carry between segments.
- Full valid/ready handshake with backpressure; reports overflow, carry-out, less-than and not-equal flags.
- Sits between the ALU operand latch and writeback in the multicycle datapath.

Parameters:
- WIDTH, 32, operand/result width in bits; WIDTH % STAGES == 0.
- STAGES, 4, pipeline segments; latency in cycles; ≥1.
- SEG, WIDTH/STAGES, bits per segment (localparam, not overridable).

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  block can accept a beat this cycle
- in_a  in  WIDTH  operand A
- in_b  in  WIDTH  operand B
- in_sub  in  1  0 = A+B+c0, 1 = A-B
- in_c0  in  1  carry-in; ignored when in_sub=1
- out_valid  out  1  result beat valid
- out_ready  in  1  consumer accepts result
- out_result  out  WIDTH  sum/difference
- out_cout  out  1  carry out of MSB
- out_ovf  out  1  signed overflow
- out_lt  out  1  signed A<B (sub only, else 0)
- out_ne  out  1  A!=B (sub only, else 0)

Behaviour:
- Reset (reset=0, asynchronous):
  - all stage valid bits and all output registers cleared to 0, immediately and irrespective of clock.
  - in-flight beats are discarded, not completed.
- Operand prep:
  - b' = in_sub ? ~in_b : in_b
  - carry-in = in_sub ? 1 : in_c0
- Stage k (0..STAGES-1):
  - computes bits [k*SEG +: SEG] with SEG-bit generate/propagate lookahead, using the carry registered by stage k-1 (stage 0 uses the prepared carry-in).
  - upper operand slices and already-finished lower result slices travel alongside in skew registers.
- Latency: STAGES cycles from the accepting edge to out_valid=1, with no stalls. Throughput is 1 beat/cycle.
- Handshake:
  - transfer occurs when valid&&ready on an edge.
  - stage k advances when it is empty or stage k+1 advances; the last stage advances when out_ready=1 or out_valid=0.
  - in_ready = !v0 || stage0 advances (combinational from out_ready through the valid chain).
  - out_* stable while out_valid=1 && out_ready=0.
  - bubbles collapse: an empty stage accepts even while downstream is stalled.
  - in_ready must be low only when every stage is occupied and out_ready=0.
- Flags, computed in the final stage:
  - ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB])
  - cout = carry out of bit WIDTH-1
  - lt = in_sub & (sum[MSB]^ovf)
  - ne = in_sub & (|sum)
- Simultaneous accept and emit in the same cycle is legal when full; no beat is lost or duplicated.
- Ordering is strictly FIFO.
- STAGES=1: one register stage; behaviour otherwise identical.

Optional Feature:
- Macro: CLA_SATURATE_EN.
- Defined: on ovf=1, out_result is clamped to the signed extreme, 0 followed by all 1s if a[MSB]=0, else 1 followed by all 0s. out_ovf is still asserted; cout, lt, ne are unchanged.
- Undefined: out_result is the wrapped sum; no clamp logic is synthesised.

Decomposition:
- Package cla_pkg:
  - localparams OP_ADD=1'b0, OP_SUB=1'b1.
  - typedef for the per-stage payload struct: valid, sub, carry, a, b', partial sum.
  - function computing SEG-bit lookahead generate/propagate.
- Sub-module cla_segment (parameter SEG): combinational SEG-bit lookahead sum, group generate/propagate and carry out. Instantiated STAGES times.
- Top level holds pipeline registers and handshake.

Test Plan:
- WIDTH=32, STAGES=4; add 1+1, c0=0, out_ready=1 → out_valid on 4th edge after accept; result 0x00000002; cout, ovf, lt, ne all 0.
- Add 0x000000FF+0x00000001 → 0x00000100 (carry crosses segment 0→1). Add 0xFFFFFFFF+1 → 0x00000000, cout=1, ovf=0.
- Add 0x7FFFFFFF+1 → ovf=1; result 0x80000000 without the macro, 0x7FFFFFFF with CLA_SATURATE_EN.
- Sub 5-7 → 0xFFFFFFFE, lt=1, ne=1, ovf=0. Sub 7-7 → 0, lt=0, ne=0, cout=1.
- Six back-to-back beats, out_ready low for cycles 2–6:
  - in_ready drops only once 4 beats are held.
  - all 6 results emerge in order, each held stable while stalled.
- Reset asserted mid-stream with 3 beats in flight → outputs 0 and in_ready=1 without a clock edge. After release, a new add 2+3 yields 5 with no stale beats.
